cmdline_text_buffer: RTL and testbench

CMDLINE_TEXT_BUFFER -- requirements
Module: cmdline_text_buffer

---
 rtl/cmdline_pkg.sv | 27 ++
 rtl/cmdline_text_buffer_char_ram.sv | 46 ++++
 rtl/cmdline_text_buffer.sv | 184 ++++++++++++++++++
 tb/tb_cmdline_text_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmdline_pkg.sv
// Shared constants, FSM state type and helpers for the command-line text buffer.
package cmdline_pkg;

  localparam int COLS_DEFAULT = 70;
  localparam int ROWS_DEFAULT = 30;
  localparam int CELLS        = COLS_DEFAULT * ROWS_DEFAULT;
  localparam int ADDR_W       = 12;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL,
    CLRROW
  } state_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASCII_SPACE) && (code <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/cmdline_text_buffer_char_ram.sv
// Character cell storage: FSM port (write plus registered read) and a
// registered read-only renderer port that returns 0x00 outside the array.
module char_ram
  import cmdline_pkg::*;
#(
  parameter int DEPTH = CELLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [7:0]        a_wdata,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic [7:0]        a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [7:0]        b_data
);

  logic [7:0] mem [DEPTH];

  // FSM write port.
  // NOTE: storage has no reset; the CLEAR sweep zeroes it, which keeps the array mappable to block RAM.
  always_ff @(posedge clk) begin
    if (a_we) begin
      // NOTE: non-blocking here so a read of the same cell this edge sees the old byte.
      mem[a_waddr] <= a_wdata;
    end
  end

  // FSM read port, used by the scroll copy one cycle ahead of its write.
  always_ff @(posedge clk) begin
    a_rdata <= mem[a_raddr];
  end

  // Renderer read port: one-cycle latency, never stalls, old data on collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_data <= ASCII_NUL;
    end else if (b_addr < ADDR_W'(DEPTH)) begin
      b_data <= mem[b_addr];
    end else begin
      b_data <= ASCII_NUL;
    end
  end

endmodule

// File: rtl/cmdline_text_buffer.sv
// Command-line text buffer: accepts ASCII codes, maintains a cursor, and
// serves the screen contents to a glyph renderer.
// Define CMDLINE_SCROLL_EN to scroll the screen up on row overflow; otherwise
// the cursor wraps to row 0 and row 0 is cleared.
module cmdline_text_buffer
  import cmdline_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [11:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam int NCELLS     = COLS * ROWS;
  localparam int SCROLL_LEN = (ROWS - 1) * COLS;
`ifdef CMDLINE_SCROLL_EN
  localparam int CLR_BASE   = SCROLL_LEN;
`else
  localparam int CLR_BASE   = 0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  logic              accept;
  logic              printable;
  logic              newline;
  logic              backspace;
  logic              last_col;
  logic              last_row;
  logic              at_origin;
  logic              row_inc;
  logic [ADDR_W-1:0] cur_addr;

  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [7:0]        a_wdata;
  logic [ADDR_W-1:0] a_raddr;
  logic [7:0]        a_rdata;

  assign accept    = in_valid && in_ready;
  assign printable = is_printable(in_data);
  assign newline   = (in_data == ASCII_LF) || (in_data == ASCII_CR);
  assign backspace = (in_data == ASCII_BS);
  assign last_col  = (cursor_x == 7'(COLS - 1));
  assign last_row  = (cursor_y == 5'(ROWS - 1));
  assign at_origin = (cursor_x == '0) && (cursor_y == '0);
  assign row_inc   = accept && (newline || (printable && last_col));
  assign cur_addr  = ADDR_W'(cursor_y) * ADDR_W'(COLS) + ADDR_W'(cursor_x);

  // Port A command: sweep writes in CLEAR/CLRROW, pipelined copy in SCROLL, key writes in IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    a_we    = 1'b0;
    a_waddr = cnt;
    a_wdata = ASCII_NUL;
    a_raddr = (cnt < ADDR_W'(SCROLL_LEN)) ? cnt + ADDR_W'(COLS) : '0;
    unique case (state)
      CLEAR: a_we = 1'b1;
      SCROLL: begin
        a_we    = (cnt != '0);
        a_waddr = cnt - ADDR_W'(1);
        a_wdata = a_rdata;
      end
      CLRROW: begin
        a_we    = 1'b1;
        a_waddr = ADDR_W'(CLR_BASE) + cnt;
      end
      IDLE: begin
        if (accept) begin
          if (printable) begin
            a_we    = 1'b1;
            a_waddr = cur_addr;
            a_wdata = in_data;
          end else if (backspace && !at_origin) begin
            a_we    = 1'b1;
            a_waddr = cur_addr - ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake/busy flags and cursor.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          if (cnt == ADDR_W'(NCELLS - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (printable && !last_col) begin
              cursor_x <= cursor_x + 7'd1;
            end else if (row_inc) begin
              cursor_x <= '0;
            end else if (backspace && !at_origin) begin
              if (cursor_x == '0) begin
                cursor_x <= 7'(COLS - 1);
                cursor_y <= cursor_y - 5'd1;
              end else begin
                cursor_x <= cursor_x - 7'd1;
              end
            end
            if (row_inc) begin
              if (!last_row) begin
                cursor_y <= cursor_y + 5'd1;
              end else begin
                in_ready <= 1'b0;
                busy     <= 1'b1;
                cnt      <= '0;
`ifdef CMDLINE_SCROLL_EN
                state    <= SCROLL;
`else
                state    <= CLRROW;
                cursor_y <= '0;
`endif
              end
            end
          end
        end
        SCROLL: begin
          // The extra final cycle drains the last read into the last copied cell.
          if (cnt == ADDR_W'(SCROLL_LEN)) begin
            state <= CLRROW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        CLRROW: begin
          if (cnt == ADDR_W'(COLS - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  char_ram #(
    .DEPTH(NCELLS)
  ) u_char_ram (
    .clk    (clk),
    .rst    (rst),
    .a_we   (a_we),
    .a_waddr(a_waddr),
    .a_wdata(a_wdata),
    .a_raddr(a_raddr),
    .a_rdata(a_rdata),
    .b_addr (rd_addr),
    .b_data (rd_data)
  );

endmodule

// File: tb/tb_cmdline_text_buffer.sv
// Self-checking bench for cmdline_text_buffer: directed scenarios plus random
// keystrokes compared against a screen-level reference model.
module tb_cmdline_text_buffer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
`ifdef CMDLINE_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
  localparam int OVF_BUSY  = (ROWS - 1) * COLS + 1 + COLS;
`else
  localparam bit SCROLL_EN = 1'b0;
  localparam int OVF_BUSY  = COLS;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [CELLS];
  int         mx;
  int         my;

  cmdline_text_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model_mem[i] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  task automatic model_next_row(output bit ovf);
    ovf = 1'b0;
    if (my < ROWS - 1) begin
      my++;
    end else begin
      ovf = 1'b1;
      if (SCROLL_EN) begin
        for (int i = 0; i < (ROWS - 1) * COLS; i++) model_mem[i] = model_mem[i + COLS];
        for (int i = (ROWS - 1) * COLS; i < CELLS; i++) model_mem[i] = 8'h00;
      end else begin
        my = 0;
        for (int i = 0; i < COLS; i++) model_mem[i] = 8'h00;
      end
    end
  endtask

  task automatic model_apply(input logic [7:0] c, output bit ovf);
    ovf = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      model_mem[my * COLS + mx] = c;
      mx++;
      if (mx == COLS) begin
        mx = 0;
        model_next_row(ovf);
      end
    end else if (c == 8'h0A || c == 8'h0D) begin
      mx = 0;
      model_next_row(ovf);
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx--;
        model_mem[my * COLS + mx] = 8'h00;
      end else if (my > 0) begin
        my--;
        mx = COLS - 1;
        model_mem[my * COLS + mx] = 8'h00;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_char(input logic [7:0] c, output bit ovf);
    int waited = 0;
    ovf = 1'b0;
    @(negedge clk);
    while (!in_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    model_apply(c, ovf);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 20000);
  endtask

  task automatic read_cell(input int a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a[11:0];
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  task automatic compare_all(input string tag);
    int errs = 0;
    logic [7:0] d;
    for (int i = 0; i < CELLS; i++) begin
      read_cell(i, d);
      if (d !== model_mem[i]) begin
        if (errs == 0) $display("  %s: first bad cell %0d got 0x%0h want 0x%0h", tag, i, d, model_mem[i]);
        errs++;
      end
    end
    check(tag, errs, 0);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, cursor_x, mx);
    check({tag, "_y"}, cursor_y, my);
  endtask

  task automatic do_reset(input int hold);
    int n;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    rd_addr  = 12'd1;
    repeat (hold) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
    check("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    count_busy(n);
    check("clear_cycles", n, CELLS);
    check_cursor("after_clear");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit          ovf;
    int          n;
    int          bad;
    logic [7:0]  d;
    logic [7:0]  c;
    int          p;

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 12'd0;
    model_clear();

    // Reset, full clear, all cells zero.
    do_reset(3);
    compare_all("clear_all_zero");

    // "AB", printable boundaries and ignored codes.
    send_char(8'h41, ovf);
    send_char(8'h42, ovf);
    read_cell(0, d); check("ab_cell0", d, 8'h41);
    read_cell(1, d); check("ab_cell1", d, 8'h42);
    check("ab_cursor_x", cursor_x, 2);
    check("ab_cursor_y", cursor_y, 0);
    send_char(8'h1F, ovf);
    send_char(8'h7F, ovf);
    check("junk_cursor_x", cursor_x, 2);
    send_char(8'h7E, ovf);
    send_char(8'h20, ovf);
    read_cell(2, d); check("tilde_cell2", d, 8'h7E);
    read_cell(3, d); check("space_cell3", d, 8'h20);
    read_cell(4, d); check("cell4_empty", d, 8'h00);
    read_cell(CELLS, d); check("oor_2100", d, 8'h00);
    read_cell(4095, d); check("oor_4095", d, 8'h00);
    read_cell(0, d); check("ab_cell0_again", d, 8'h41);

    // Row wrap, carriage return, backspace across rows, backspace at origin.
    do_reset(2);
    send_char(8'h08, ovf);
    check("bs_origin_x", cursor_x, 0);
    check("bs_origin_y", cursor_y, 0);
    for (int i = 0; i < COLS; i++) send_char(8'h41, ovf);
    check("wrap_cursor_x", cursor_x, 0);
    check("wrap_cursor_y", cursor_y, 1);
    send_char(8'h0D, ovf);
    check("cr_cursor_x", cursor_x, 0);
    check("cr_cursor_y", cursor_y, 2);
    read_cell(70, d); check("cell70", d, 8'h00);
    send_char(8'h08, ovf);
    check("bs_row_x", cursor_x, 69);
    check("bs_row_y", cursor_y, 1);
    read_cell(139, d); check("cell139", d, 8'h00);
    read_cell(69, d); check("cell69", d, 8'h41);
    send_char(8'h08, ovf);
    send_char(8'h08, ovf);
    compare_all("bs_screen");
    check_cursor("bs_screen");

    // Fill screen, overflow with LF while holding a code during busy.
    do_reset(2);
    for (int r = 0; r < ROWS - 1; r++)
      for (int col = 0; col < COLS; col++) send_char(8'(8'h30 + r % 10), ovf);
    for (int col = 0; col < 5; col++) send_char(8'h39, ovf);
    check("fill_cursor_x", cursor_x, 5);
    check("fill_cursor_y", cursor_y, 29);
    send_char(8'h0A, ovf);
    check("fill_overflow_seen", ovf, 1);
    in_valid = 1'b1;
    in_data  = 8'h41;
    n   = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (cursor_x !== mx[6:0] || cursor_y !== my[4:0]) bad++;
    end while (busy && n < 20000);
    check("ovf_busy_cycles", n, OVF_BUSY);
    check("hold_no_cursor_move", bad, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_apply(8'h41, ovf);
    check_cursor("held_one_accept");
`ifdef CMDLINE_SCROLL_EN
    read_cell(0, d);    check("scroll_row0", d, 8'h31);
    read_cell(1960, d); check("scroll_row28", d, 8'h39);
    read_cell(2030, d); check("scroll_held_char", d, 8'h41);
    read_cell(2031, d); check("scroll_row29_clear", d, 8'h00);
`else
    read_cell(0, d);    check("wrap_held_char", d, 8'h41);
    read_cell(1, d);    check("wrap_row0_clear", d, 8'h00);
    read_cell(70, d);   check("wrap_row1", d, 8'h31);
    read_cell(2030, d); check("wrap_row29", d, 8'h39);
`endif
    compare_all("after_overflow");

    // Reset in the middle of the overflow operation.
    ovf = 1'b0;
    for (int i = 0; i < 40 && !ovf; i++) send_char(8'h0A, ovf);
    check("second_overflow_seen", ovf, 1);
    repeat (25) @(posedge clk);
    #1;
    check("mid_op_busy", busy, 1);
    do_reset(1);
    compare_all("reset_mid_op_zero");

    // Random keystrokes against the model.
    for (int k = 0; k < 600; k++) begin
      p = $urandom_range(0, 99);
      if (p < 70) begin
        c = 8'($urandom_range(32, 126));
      end else if (p < 78) begin
        c = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
      end else if (p < 90) begin
        c = 8'h08;
      end else begin
        c = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 31));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0D) c = 8'h7F;
      end
      send_char(c, ovf);
      if (ovf) begin
        count_busy(n);
        check("rand_ovf_busy", n, OVF_BUSY);
      end
      check_cursor("rand_cursor");
    end
    compare_all("random_screen");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
